imm_gen_pipe: RTL and testbench

//   Registered, parametrised RV immediate generator for the decode stage. Accepts a full 32-bit

---
 rtl/rv_imm_pkg.sv | 71 +++++++
 rtl/imm_decode_comb.sv | 23 ++
 rtl/imm_gen_pipe.sv | 108 ++++++++++
 tb/tb_imm_gen_pipe.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_imm_pkg.sv
// rtl/rv_imm_pkg.sv - RV immediate format codes, opcodes and the shared decode function
package rv_imm_pkg;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_I,
    FMT_ISH,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } imm_fmt_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Every base-format immediate fits a sign-extended 32-bit value; wider XLEN extends bit 31.
  typedef struct packed {
    logic [31:0] imm;
    imm_fmt_e    fmt;
  } imm_dec_t;

  function automatic imm_dec_t imm_decode(input logic [31:0] instr, input logic shamt6);
    imm_dec_t r;
    logic [2:0] funct3;
    r.imm  = '0;
    r.fmt  = FMT_NONE;
    funct3 = instr[14:12];
    case (instr[6:0])
      OPC_OPIMM: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          r.fmt = FMT_ISH;
          r.imm = shamt6 ? {26'b0, instr[25:20]} : {27'b0, instr[24:20]};
        end else begin
          r.fmt = FMT_I;
          r.imm = {{20{instr[31]}}, instr[31:20]};
        end
      end
      OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
        r.fmt = FMT_I;
        r.imm = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_STORE: begin
        r.fmt = FMT_S;
        r.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_BRANCH: begin
        r.fmt = FMT_B;
        r.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        r.fmt = FMT_U;
        r.imm = {instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        r.fmt = FMT_J;
        r.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/imm_decode_comb.sv
// rtl/imm_decode_comb.sv - combinational instruction-to-immediate decoder, XLEN-wide result
module imm_decode_comb
  import rv_imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output imm_fmt_e        fmt_o
);

  imm_dec_t dec;

  assign dec   = imm_decode(instr_i, XLEN == 64);
  assign fmt_o = dec.fmt;

  if (XLEN == 64) begin : g_x64
    assign imm_o = {{32{dec.imm[31]}}, dec.imm};
  end else begin : g_x32
    assign imm_o = dec.imm;
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered immediate generator with a one-entry skid buffer
module imm_gen_pipe
  import rv_imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [TAG_W-1:0] out_tag
);

  logic [XLEN-1:0]  dec_imm;
  imm_fmt_e         dec_fmt;

  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  out_imm_q, out_imm_d;
  imm_fmt_e         out_fmt_q, out_fmt_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
  imm_fmt_e         skid_fmt_q, skid_fmt_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;

  logic             accept;
  logic             drain;

  imm_decode_comb #(.XLEN(XLEN)) u_decode (
    .instr_i (in_instr),
    .imm_o   (dec_imm),
    .fmt_o   (dec_fmt)
  );

  // in_ready comes straight from the skid flop so it never depends on out_ready.
  assign accept = in_valid & ~skid_valid_q;
  assign drain  = out_valid_q & out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_imm_d    = out_imm_q;
    out_fmt_d    = out_fmt_q;
    out_tag_d    = out_tag_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_fmt_d   = skid_fmt_q;
    skid_tag_d   = skid_tag_q;
    if (skid_valid_q) begin
      if (drain) begin
        out_imm_d    = skid_imm_q;
        out_fmt_d    = skid_fmt_q;
        out_tag_d    = skid_tag_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_q || out_ready) begin
        out_valid_d = 1'b1;
        out_imm_d   = dec_imm;
        out_fmt_d   = dec_fmt;
        out_tag_d   = in_tag;
      end else begin
        skid_valid_d = 1'b1;
        skid_imm_d   = dec_imm;
        skid_fmt_d   = dec_fmt;
        skid_tag_d   = in_tag;
      end
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_fmt_q    <= FMT_NONE;
      out_tag_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_fmt_q   <= FMT_NONE;
      skid_tag_q   <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_imm_q    <= out_imm_d;
      out_fmt_q    <= out_fmt_d;
      out_tag_q    <= out_tag_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_fmt_q   <= skid_fmt_d;
      skid_tag_q   <= skid_tag_d;
    end
  end

  assign in_ready  = ~skid_valid_q;
  assign out_valid = out_valid_q;
  assign out_imm   = out_imm_q;
  assign out_fmt   = out_fmt_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - random and directed bench for imm_gen_pipe at XLEN 32 and 64
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_tag;
  logic        out_ready;

  logic        in_ready32, out_valid32;
  logic [31:0] out_imm32;
  logic [2:0]  out_fmt32;
  logic [31:0] out_tag32;

  logic        in_ready64, out_valid64;
  logic [63:0] out_imm64;
  logic [2:0]  out_fmt64;
  logic [31:0] out_tag64;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  typedef struct {
    logic [63:0] imm;
    int          fmt;
    logic [31:0] tag;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_fmt(out_fmt32), .out_tag(out_tag32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_fmt(out_fmt64), .out_tag(out_tag64)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Signed value of a w-bit field held in the low bits of v.
  function automatic longint sx(input longint v, input int w);
    if (((v >> (w - 1)) & 1) != 0) return v - (longint'(1) << w);
    return v;
  endfunction

  function automatic exp_t ref_dec(input logic [31:0] instr, input int xlen);
    exp_t   e;
    longint i = longint'({32'b0, instr});
    longint op = i & 'h7f;
    longint f3 = (i >> 12) & 7;
    longint v = 0;
    e.fmt = 0;
    if (op == 'h13 && (f3 == 1 || f3 == 5)) begin
      e.fmt = 2;
      v = (i >> 20) & ((xlen == 64) ? 63 : 31);
    end else if (op == 'h13 || op == 'h03 || op == 'h67 || op == 'h73) begin
      e.fmt = 1;
      v = sx((i >> 20) & 'hfff, 12);
    end else if (op == 'h23) begin
      e.fmt = 3;
      v = sx((((i >> 25) & 127) << 5) | ((i >> 7) & 31), 12);
    end else if (op == 'h63) begin
      e.fmt = 4;
      v = sx((((i >> 31) & 1) << 12) | (((i >> 7) & 1) << 11) |
             (((i >> 25) & 63) << 5) | (((i >> 8) & 15) << 1), 13);
    end else if (op == 'h37 || op == 'h17) begin
      e.fmt = 5;
      v = sx(i & 'hFFFFF000, 32);
    end else if (op == 'h6f) begin
      e.fmt = 6;
      v = sx((((i >> 31) & 1) << 20) | (((i >> 12) & 255) << 12) |
             (((i >> 20) & 1) << 11) | (((i >> 21) & 1023) << 1), 21);
    end
    e.imm = (xlen == 64) ? 64'(v) : 64'(v & 'hFFFFFFFF);
    e.tag = 32'h0;
    return e;
  endfunction

  task automatic check_side(input string nm, input exp_t q[$], input logic ov, input logic ir,
                            input logic [63:0] imm, input logic [2:0] fmt, input logic [31:0] tg);
    chk({nm, "_out_valid"}, 64'(ov), 64'(q.size() > 0));
    chk({nm, "_in_ready"}, 64'(ir), 64'(q.size() < 2));
    if (q.size() > 0 && ov) begin
      chk({nm, "_imm"}, imm, q[0].imm);
      chk({nm, "_fmt"}, 64'(fmt), 64'(q[0].fmt));
      chk({nm, "_tag"}, 64'(tg), 64'(q[0].tag));
    end
  endtask

  // Model: the block is a FIFO of at most two beats; ready while fewer than two are held.
  always @(negedge clk) begin
    if (check_en) begin
      bit   acc, drn;
      exp_t e;
      check_side("x32", q32, out_valid32, in_ready32, 64'(out_imm32), out_fmt32, out_tag32);
      check_side("x64", q64, out_valid64, in_ready64, out_imm64, out_fmt64, out_tag64);
      if (reset) begin
        q32.delete();
        q64.delete();
      end else begin
        acc = in_valid && (q32.size() < 2);
        drn = (q32.size() > 0) && out_ready;
        if (drn) begin
          void'(q32.pop_front());
          void'(q64.pop_front());
        end
        if (acc) begin
          e = ref_dec(in_instr, 32); e.tag = in_tag; q32.push_back(e);
          e = ref_dec(in_instr, 64); e.tag = in_tag; q64.push_back(e);
        end
      end
    end
  end

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [9] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f};
    logic [31:0] r = $urandom;
    int          sel = $urandom_range(0, 10);
    if (sel < 9) r[6:0] = ops[sel];
    return r;
  endfunction

  logic [31:0] d_instr [8] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h123452B7,
                               32'h001000EF, 32'h01F09093, 32'h41F0D093, 32'h00000033};
  logic [63:0] d_imm64 [8] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8,
                               64'h0000000012345000, 64'h800, 64'h1F, 64'h1F, 64'h0};
  int          d_fmt   [8] = '{1, 3, 4, 5, 6, 2, 2, 0};

  initial begin
    exp_t e;
    bit   acc;
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_tag = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; check_en = 1'b1;

    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid32), 64'h0);
    chk("rst_in_ready", 64'(in_ready32), 64'h1);
    chk("rst_imm", 64'(out_imm32), 64'h0);
    chk("rst_fmt", 64'(out_fmt32), 64'h0);
    chk("rst_tag", 64'(out_tag64), 64'h0);

    for (int k = 0; k < 8; k++) begin
      e = ref_dec(d_instr[k], 64);
      chk("model_pin64", e.imm, d_imm64[k]);
      e = ref_dec(d_instr[k], 32);
      chk("model_pin32", e.imm, d_imm64[k] & 64'hFFFFFFFF);
      chk("model_pin_fmt", 64'(e.fmt), 64'(d_fmt[k]));
    end

    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1 in_valid = 1'b1; in_instr = d_instr[k]; in_tag = 32'(k);
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      chk("dir_valid", 64'(out_valid32), 64'h1);
      chk("dir_imm32", 64'(out_imm32), d_imm64[k] & 64'hFFFFFFFF);
      chk("dir_imm64", out_imm64, d_imm64[k]);
      chk("dir_fmt", 64'(out_fmt32), 64'(d_fmt[k]));
    end

    // Back-pressure: A held at output, B in skid, C stalled at the source.
    @(posedge clk); #1 out_ready = 1'b0; in_valid = 1'b1; in_instr = d_instr[0]; in_tag = 32'hA;
    @(posedge clk); #1 in_instr = d_instr[1]; in_tag = 32'hB;
    @(posedge clk); #1 in_instr = d_instr[2]; in_tag = 32'hC;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready32), 64'h0);
      chk("bp_hold_tag", 64'(out_tag32), 64'hA);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk); chk("rel_tag_a", 64'(out_tag32), 64'hA);
    @(posedge clk); #1;
    @(negedge clk); chk("rel_tag_b", 64'(out_tag32), 64'hB);
    chk("rel_in_ready", 64'(in_ready32), 64'h1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk); chk("rel_tag_c", 64'(out_tag32), 64'hC);
    @(posedge clk); #1;
    @(negedge clk); chk("rel_empty", 64'(out_valid32), 64'h0);

    // Reset with both registers full.
    @(posedge clk); #1 out_ready = 1'b0; in_valid = 1'b1; in_instr = d_instr[3]; in_tag = 32'hD;
    @(posedge clk); #1 in_instr = d_instr[4]; in_tag = 32'hE;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk); chk("full_in_ready", 64'(in_ready64), 64'h0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 64'(out_valid32), 64'h0);
    chk("mid_rst_ready", 64'(in_ready32), 64'h1);
    chk("mid_rst_fmt", 64'(out_fmt64), 64'h0);

    @(posedge clk); #1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = in_valid & in_ready32;
      @(posedge clk); #1;
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_instr = rand_instr();
        in_tag   = $urandom;
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    acc = in_valid & in_ready32;
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;

    repeat (6) @(negedge clk);
    chk("drain_q32", 64'(q32.size()), 64'h0);
    chk("drain_q64", 64'(q64.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
